// File: rtl/lmac_rx_pkg.sv
// Shared definitions for the LMAC RX FIFO to stream bridge.
// Holds the control-word field positions, the buffer geometry, the framing
// FSM state type and the byte-count and keep helpers.
package lmac_rx_pkg;

   localparam int DATA_W         = 256;
   localparam int BYTES_PER_WORD = 32;
   localparam int BUF_DEPTH      = 2;
   localparam int WCNT_W         = 9;
   localparam int BEAT_W         = DATA_W + BYTES_PER_WORD + 2;

   localparam int CTRL_SOP_BIT   = 0;
   localparam int CTRL_EOP_BIT   = 1;
   localparam int CTRL_ERR_BIT   = 2;
   localparam int CTRL_BCNT_LSB  = 4;
   localparam int CTRL_BCNT_W    = 5;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      IN_PKT  = 2'd1,
      DISCARD = 2'd2
   } rx_state_e;

   // A last-word byte count of 0 means the whole word is valid.
   function automatic logic [BYTES_PER_WORD-1:0] bcnt_to_keep(input logic [CTRL_BCNT_W-1:0] bcnt);
      if (bcnt == '0) return '1;
      return (BYTES_PER_WORD'(1) << bcnt) - BYTES_PER_WORD'(1);
   endfunction

   function automatic logic [5:0] keep_bytes(input logic [BYTES_PER_WORD-1:0] keep);
      logic [5:0] n;
      n = '0;
      for (int i = 0; i < BYTES_PER_WORD; i++) n = n + {5'd0, keep[i]};
      return n;
   endfunction

endpackage

// File: rtl/lmac_skid_fifo2.sv
// Two-entry valid/ready buffer between the framing FSM and the stream port.
// Ports: clk, reset_ (async active low); push/push_data write side (the
// caller never pushes into a full buffer); valid/ready/data read side;
// count gives the number of stored entries.
module lmac_skid_fifo2 #(
   parameter int W = 290
) (
   input  logic         clk,
   input  logic         reset_,
   input  logic         push,
   input  logic [W-1:0] push_data,
   output logic         valid,
   input  logic         ready,
   output logic [W-1:0] data,
   output logic [1:0]   count
);

   logic [W-1:0] mem [2];
   logic         wr_ptr;
   logic         rd_ptr;
   logic [1:0]   cnt;
   logic         pop;

   assign valid = (cnt != 2'd0);
   assign pop   = valid & ready;
   assign data  = mem[rd_ptr];
   assign count = cnt;

   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         for (int i = 0; i < 2; i++) mem[i] <= '0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         cnt    <= 2'd0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= ~wr_ptr;
         end
         if (pop) rd_ptr <= ~rd_ptr;
         cnt <= cnt + {1'b0, push} - {1'b0, pop};
      end
   end

endmodule

// File: rtl/lmac_rx_axis_bridge.sv
// Pops 256-bit words from the LMAC RX FIFO, checks SOP/EOP framing and the
// maximum packet length, and presents packets as a valid/ready stream with
// byte enables, last and bad-packet flags. Keeps packet/byte/error counters.
// Ports: clk, reset_ (async active low); rx_mac_* RX FIFO read side;
// drain_en gates new reads; stat_clr clears the counters; m_t* stream
// output; stat_* counters.
//
// state   | meaning
// IDLE    | between packets, next word must carry SOP
// IN_PKT  | inside a packet, wcnt words already emitted
// DISCARD | dropping words until the next SOP
module lmac_rx_axis_bridge
   import lmac_rx_pkg::*;
#(
   parameter int MAX_WORDS = 300
) (
   input  logic                      clk,
   input  logic                      reset_,
   input  logic [DATA_W-1:0]         rx_mac_data,
   input  logic [31:0]               rx_mac_ctrl,
   input  logic                      rx_mac_empty,
   output logic                      rx_mac_rd,
   input  logic                      drain_en,
   input  logic                      stat_clr,
   output logic [DATA_W-1:0]         m_tdata,
   output logic [BYTES_PER_WORD-1:0] m_tkeep,
   output logic                      m_tlast,
   output logic                      m_tuser,
   output logic                      m_tvalid,
   input  logic                      m_tready,
   output logic [31:0]               stat_pkt_cnt,
   output logic [47:0]               stat_byte_cnt,
   output logic [15:0]               stat_err_cnt
);

   logic                      run_q;
   logic                      inflight_q;
   rx_state_e                 state_q, state_d;
   logic [WCNT_W-1:0]         wcnt_q, wcnt_d;
   logic                      emit, last, user, err_inc;
   logic [BYTES_PER_WORD-1:0] keep;
   logic [1:0]                occ;
   logic                      pop;
   logic [2:0]                pending;
   logic [BEAT_W-1:0]         fifo_out;

   logic                      sop, eop, perr;
   logic [CTRL_BCNT_W-1:0]    bcnt;
   logic                      unused_ctrl;

   assign sop  = rx_mac_ctrl[CTRL_SOP_BIT];
   assign eop  = rx_mac_ctrl[CTRL_EOP_BIT];
   assign perr = rx_mac_ctrl[CTRL_ERR_BIT];
   assign bcnt = rx_mac_ctrl[CTRL_BCNT_LSB +: CTRL_BCNT_W];
   assign unused_ctrl = ^{rx_mac_ctrl[31:CTRL_BCNT_LSB+CTRL_BCNT_W], rx_mac_ctrl[3]};

   // A beat leaving the buffer this cycle frees its slot before a read issued
   // now can land (two cycles later at the earliest), so it is not counted.
   // That keeps one word per cycle with m_tready high and still never lets a
   // returning word find the buffer full.
   assign pop       = m_tvalid & m_tready;
   assign pending   = {1'b0, occ} + {2'b0, inflight_q} - {2'b0, pop};
   assign rx_mac_rd = run_q & drain_en & ~rx_mac_empty & (pending < 3'(BUF_DEPTH));

   always_comb begin
      state_d = state_q;
      wcnt_d  = wcnt_q;
      emit    = 1'b0;
      last    = 1'b0;
      user    = 1'b0;
      err_inc = 1'b0;
      keep    = eop ? bcnt_to_keep(bcnt) : '1;
      if (inflight_q) begin
         unique case (state_q)
            IDLE, DISCARD: begin
               if (sop) begin
                  emit = 1'b1;
                  if (eop) begin
                     last    = 1'b1;
                     user    = perr;
                     err_inc = perr;
                     state_d = IDLE;
                  end else begin
                     wcnt_d  = WCNT_W'(1);
                     state_d = IN_PKT;
                  end
               end else if (state_q == IDLE) begin
                  err_inc = 1'b1;
                  state_d = DISCARD;
               end
            end
            IN_PKT: begin
               if (sop) begin
                  // A new SOP inside a packet closes the old one as bad and
                  // the new packet is lost along with it.
                  emit    = 1'b1;
                  last    = 1'b1;
                  user    = 1'b1;
                  keep    = '1;
                  err_inc = 1'b1;
                  state_d = DISCARD;
               end else if (eop) begin
                  emit    = 1'b1;
                  last    = 1'b1;
                  user    = perr;
                  err_inc = perr;
                  state_d = IDLE;
               end else if (wcnt_q == WCNT_W'(MAX_WORDS - 1)) begin
                  emit    = 1'b1;
                  last    = 1'b1;
                  user    = 1'b1;
                  err_inc = 1'b1;
                  state_d = DISCARD;
               end else begin
                  emit   = 1'b1;
                  wcnt_d = wcnt_q + WCNT_W'(1);
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         run_q      <= 1'b0;
         inflight_q <= 1'b0;
         state_q    <= IDLE;
         wcnt_q     <= '0;
      end else begin
         run_q      <= 1'b1;
         inflight_q <= rx_mac_rd;
         state_q    <= state_d;
         wcnt_q     <= wcnt_d;
      end
   end

   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         stat_pkt_cnt  <= '0;
         stat_byte_cnt <= '0;
         stat_err_cnt  <= '0;
      end else if (stat_clr) begin
         stat_pkt_cnt  <= '0;
         stat_byte_cnt <= '0;
         stat_err_cnt  <= '0;
      end else begin
         if (pop) begin
            stat_pkt_cnt  <= stat_pkt_cnt + {31'd0, m_tlast};
            stat_byte_cnt <= stat_byte_cnt + {42'd0, keep_bytes(m_tkeep)};
         end
         if (err_inc && (stat_err_cnt != 16'hFFFF)) stat_err_cnt <= stat_err_cnt + 16'd1;
      end
   end

   lmac_skid_fifo2 #(.W(BEAT_W)) u_buf (
      .clk       (clk),
      .reset_    (reset_),
      .push      (emit),
      .push_data ({rx_mac_data, keep, last, user}),
      .valid     (m_tvalid),
      .ready     (m_tready),
      .data      (fifo_out),
      .count     (occ)
   );

   assign {m_tdata, m_tkeep, m_tlast, m_tuser} = fifo_out;

endmodule

// File: tb/tb_lmac_rx_axis_bridge.sv
module tb_lmac_rx_axis_bridge;

   typedef struct packed {
      logic [255:0] data;
      logic [31:0]  keep;
      logic         last;
      logic         user;
   } beat_t;

   typedef struct packed {
      logic [255:0] data;
      logic [31:0]  ctrl;
   } src_t;

   logic         clk;
   logic         reset_;
   logic [255:0] rx_mac_data;
   logic [31:0]  rx_mac_ctrl;
   logic         rx_mac_empty;
   logic         rx_mac_rd;
   logic         drain_en;
   logic         stat_clr;
   logic [255:0] m_tdata;
   logic [31:0]  m_tkeep;
   logic         m_tlast;
   logic         m_tuser;
   logic         m_tvalid;
   logic         m_tready;
   logic [31:0]  stat_pkt_cnt;
   logic [47:0]  stat_byte_cnt;
   logic [15:0]  stat_err_cnt;

   int           checks = 0;
   int           passed = 0;
   longint       cyc = 0;
   src_t         src_q[$];
   beat_t        exp_q[$];
   longint       beat_cyc[$];
   int           ready_pct = 100;
   int           drain_pct = 100;
   int           gap_pct = 0;
   logic         clr_hold = 1'b0;
   logic [31:0]  exp_pkt = '0;
   logic [47:0]  exp_byte = '0;
   logic [15:0]  exp_err = '0;

   lmac_rx_axis_bridge dut (
      .clk           (clk),
      .reset_        (reset_),
      .rx_mac_data   (rx_mac_data),
      .rx_mac_ctrl   (rx_mac_ctrl),
      .rx_mac_empty  (rx_mac_empty),
      .rx_mac_rd     (rx_mac_rd),
      .drain_en      (drain_en),
      .stat_clr      (stat_clr),
      .m_tdata       (m_tdata),
      .m_tkeep       (m_tkeep),
      .m_tlast       (m_tlast),
      .m_tuser       (m_tuser),
      .m_tvalid      (m_tvalid),
      .m_tready      (m_tready),
      .stat_pkt_cnt  (stat_pkt_cnt),
      .stat_byte_cnt (stat_byte_cnt),
      .stat_err_cnt  (stat_err_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h required %0h", name, act, exp);
   endtask

   function automatic logic [255:0] rnd_data();
      logic [255:0] d;
      for (int i = 0; i < 8; i++) d[i*32 +: 32] = $urandom();
      return d;
   endfunction

   function automatic logic [31:0] keep_of(input logic [4:0] n);
      logic [31:0] k;
      if (n == 5'd0) return 32'hFFFF_FFFF;
      k = '0;
      for (int i = 0; i < 32; i++) if (i < int'(n)) k[i] = 1'b1;
      return k;
   endfunction

   // Ignored control bits carry random junk to make sure they stay ignored.
   task automatic put(input logic [255:0] d, input logic sop, input logic eop,
                      input logic err, input logic [4:0] bcnt);
      src_t s;
      s.data    = d;
      s.ctrl    = $urandom() & 32'hFFFF_FE08;
      s.ctrl[0] = sop;
      s.ctrl[1] = eop;
      s.ctrl[2] = err;
      s.ctrl[8:4] = bcnt;
      src_q.push_back(s);
   endtask

   task automatic expect_beat(input logic [255:0] d, input logic [31:0] keep,
                              input logic last, input logic user);
      beat_t b;
      b.data = d;
      b.keep = keep;
      b.last = last;
      b.user = user;
      exp_q.push_back(b);
      if (!clr_hold) begin
         exp_pkt  = exp_pkt + {31'd0, last};
         exp_byte = exp_byte + 48'($countones(keep));
      end
   endtask

   task automatic wait_idle(input int budget, input string name);
      int n = 0;
      while ((src_q.size() != 0 || exp_q.size() != 0) && n < budget) begin
         @(posedge clk);
         n++;
      end
      checks++;
      if (n >= budget)
         $display("FAIL %s_timeout: %0d beats still outstanding after %0d cycles, required 0",
                  name, exp_q.size(), budget);
      else passed++;
      repeat (6) @(posedge clk);
   endtask

   task automatic chk_stats(input string tag);
      @(negedge clk);
      chk({tag, "_pkt_cnt"},  256'(stat_pkt_cnt),  256'(exp_pkt));
      chk({tag, "_byte_cnt"}, 256'(stat_byte_cnt), 256'(exp_byte));
      chk({tag, "_err_cnt"},  256'(stat_err_cnt),  256'(exp_err));
      @(posedge clk);
   endtask

   // RX FIFO model: a pop seen before the edge returns its word after it.
   initial begin : src_proc
      logic rd_s;
      rx_mac_empty = 1'b1;
      rx_mac_data  = '0;
      rx_mac_ctrl  = '0;
      forever begin
         @(negedge clk);
         rd_s = rx_mac_rd;
         @(posedge clk);
         #1;
         if (rd_s && src_q.size() > 0) begin
            rx_mac_data = src_q[0].data;
            rx_mac_ctrl = src_q[0].ctrl;
            void'(src_q.pop_front());
         end else begin
            if (rd_s) begin
               checks++;
               $display("FAIL read_while_empty: rx_mac_rd=1 with empty source, required 0");
            end
            rx_mac_data = rnd_data();
            rx_mac_ctrl = $urandom();
         end
         rx_mac_empty = (src_q.size() == 0) || ($urandom_range(99, 0) < gap_pct);
      end
   end

   initial begin
      m_tready = 1'b1;
      drain_en = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         m_tready = ($urandom_range(99, 0) < ready_pct);
         drain_en = ($urandom_range(99, 0) < drain_pct);
      end
   end

   initial begin : monitor
      beat_t e;
      forever begin
         @(negedge clk);
         if (reset_ && m_tvalid && m_tready) begin
            beat_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
               checks++;
               $display("FAIL unexpected_beat: got data %0h, required no beat", m_tdata);
            end else begin
               e = exp_q.pop_front();
               chk("beat_data", m_tdata, e.data);
               chk("beat_keep", 256'(m_tkeep), 256'(e.keep));
               chk("beat_last", 256'(m_tlast), 256'(e.last));
               chk("beat_user", 256'(m_tuser), 256'(e.user));
            end
         end
      end
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   initial begin : main
      logic [255:0] d0, d1, d2, d3, d4;
      int n;
      reset_   = 1'b0;
      stat_clr = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_rd",     256'(rx_mac_rd), 256'd0);
      chk("rst_tvalid", 256'(m_tvalid),  256'd0);
      chk("rst_tdata",  m_tdata,         256'd0);
      chk("rst_tkeep",  256'(m_tkeep),   256'd0);
      chk("rst_tlast",  256'(m_tlast),   256'd0);
      @(posedge clk);
      #2 reset_ = 1'b1;
      repeat (2) @(posedge clk);

      // 3-word packet, last word 5 bytes, streamed back to back
      beat_cyc.delete();
      d0 = rnd_data(); d1 = rnd_data(); d2 = rnd_data();
      put(d0, 1, 0, 0, 5'd0);
      put(d1, 0, 0, 0, 5'd0);
      put(d2, 0, 1, 0, 5'd5);
      expect_beat(d0, 32'hFFFF_FFFF, 0, 0);
      expect_beat(d1, 32'hFFFF_FFFF, 0, 0);
      expect_beat(d2, 32'h0000_001F, 1, 0);
      wait_idle(100, "t1");
      chk("t1_beat_count", 256'(beat_cyc.size()), 256'd3);
      if (beat_cyc.size() == 3) chk("t1_back_to_back", 256'(beat_cyc[2] - beat_cyc[0]), 256'd2);
      chk_stats("t1");

      // single-word packet, byte count 0 = full word, MAC error
      d0 = rnd_data();
      put(d0, 1, 1, 1, 5'd0);
      expect_beat(d0, 32'hFFFF_FFFF, 1, 1);
      exp_err = exp_err + 16'd1;
      wait_idle(100, "t2");
      chk_stats("t2");

      // stray word in IDLE is dropped, following packet intact
      d0 = rnd_data(); d1 = rnd_data(); d2 = rnd_data();
      put(d0, 0, 0, 0, 5'd7);
      exp_err = exp_err + 16'd1;
      put(d1, 1, 0, 0, 5'd0);
      put(d2, 0, 1, 0, 5'd8);
      expect_beat(d1, 32'hFFFF_FFFF, 0, 0);
      expect_beat(d2, 32'h0000_00FF, 1, 0);
      wait_idle(100, "t3");
      chk_stats("t3");

      // SOP inside a packet truncates it; rest of the new packet dropped
      d0 = rnd_data(); d1 = rnd_data(); d2 = rnd_data(); d3 = rnd_data(); d4 = rnd_data();
      put(d0, 1, 0, 0, 5'd0);
      put(d1, 0, 0, 0, 5'd0);
      put(d2, 1, 0, 0, 5'd0);
      put(d3, 0, 0, 0, 5'd0);
      put(d4, 0, 1, 0, 5'd2);
      expect_beat(d0, 32'hFFFF_FFFF, 0, 0);
      expect_beat(d1, 32'hFFFF_FFFF, 0, 0);
      expect_beat(d2, 32'hFFFF_FFFF, 1, 1);
      exp_err = exp_err + 16'd1;
      wait_idle(100, "t3b");
      chk_stats("t3b");

      // stat_clr
      @(posedge clk); #1 stat_clr = 1'b1;
      @(posedge clk); #1 stat_clr = 1'b0;
      exp_pkt = '0; exp_byte = '0; exp_err = '0;
      chk_stats("clr");

      // clear held during a bad packet: clear beats every increment
      clr_hold = 1'b1;
      @(posedge clk); #1 stat_clr = 1'b1;
      d0 = rnd_data();
      put(d0, 1, 1, 1, 5'd3);
      expect_beat(d0, 32'h0000_0007, 1, 1);
      wait_idle(100, "clr_wins");
      chk_stats("clr_wins");
      #1 stat_clr = 1'b0;
      clr_hold = 1'b0;

      // over-length packet: beat 300 closes it as bad, tail dropped
      for (int w = 1; w <= 302; w++) begin
         d0 = rnd_data();
         put(d0, w == 1, w == 302, 0, (w == 302) ? 5'd3 : 5'd0);
         if (w <= 300) expect_beat(d0, 32'hFFFF_FFFF, w == 300, w == 300);
      end
      exp_err = exp_err + 16'd1;
      d1 = rnd_data();
      put(d1, 1, 1, 0, 5'd4);
      expect_beat(d1, 32'h0000_000F, 1, 0);
      wait_idle(2000, "t4");
      chk_stats("t4");

      // 1000 well-formed packets with random ready, drain and supply gaps
      ready_pct = 50; drain_pct = 85; gap_pct = 20;
      for (int p = 0; p < 1000; p++) begin
         int len;
         logic e;
         logic [4:0] bc;
         len = $urandom_range(4, 1);
         e   = ($urandom_range(7, 0) == 0);
         bc  = 5'($urandom_range(31, 0));
         for (int w = 0; w < len; w++) begin
            d0 = rnd_data();
            put(d0, w == 0, w == len - 1, e && (w == len - 1), (w == len - 1) ? bc : 5'($urandom()));
            expect_beat(d0, (w == len - 1) ? keep_of(bc) : 32'hFFFF_FFFF, w == len - 1, e && (w == len - 1));
         end
         if (e) exp_err = exp_err + 16'd1;
      end
      wait_idle(40000, "t5");
      ready_pct = 100; drain_pct = 100; gap_pct = 0;
      repeat (3) @(posedge clk);
      chk_stats("t5");

      // reset mid-packet while the stream is stalled with valid data
      ready_pct = 0;
      repeat (2) @(posedge clk);
      put(rnd_data(), 1, 0, 0, 5'd0);
      put(rnd_data(), 0, 0, 0, 5'd0);
      put(rnd_data(), 0, 0, 0, 5'd0);
      n = 0;
      while (!m_tvalid && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("t6_valid_before_reset", 256'(m_tvalid), 256'd1);
      repeat (3) @(posedge clk);
      @(posedge clk);
      #2 reset_ = 1'b0;
      src_q.delete();
      exp_q.delete();
      #1;
      chk("t6_rst_tvalid", 256'(m_tvalid),      256'd0);
      chk("t6_rst_tdata",  m_tdata,             256'd0);
      chk("t6_rst_tkeep",  256'(m_tkeep),       256'd0);
      chk("t6_rst_tlast",  256'(m_tlast),       256'd0);
      chk("t6_rst_tuser",  256'(m_tuser),       256'd0);
      chk("t6_rst_rd",     256'(rx_mac_rd),     256'd0);
      chk("t6_rst_pkt",    256'(stat_pkt_cnt),  256'd0);
      chk("t6_rst_byte",   256'(stat_byte_cnt), 256'd0);
      chk("t6_rst_err",    256'(stat_err_cnt),  256'd0);
      exp_pkt = '0; exp_byte = '0; exp_err = '0;
      repeat (3) @(posedge clk);
      #2 reset_ = 1'b1;
      ready_pct = 100;
      d0 = rnd_data(); d1 = rnd_data();
      put(d0, 1, 0, 0, 5'd0);
      put(d1, 0, 1, 0, 5'd17);
      expect_beat(d0, 32'hFFFF_FFFF, 0, 0);
      expect_beat(d1, 32'h0001_FFFF, 1, 0);
      wait_idle(100, "t6");
      chk_stats("t6");

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
